// File: rtl/vector_issue_ctrl_pkg.sv
// Shared vector types for the issue controller (stands in for the shared
// vstructs definitions): configuration widths, the to_vector instruction
// payload, the issue FSM state type and a small FU-select helper.
// No ports; imported with `import vector_issue_ctrl_pkg::*`.
package vector_issue_ctrl_pkg;

  localparam int VECTOR_REGISTERS = 32;
  localparam int VECTOR_LANES     = 8;
  localparam int VLW              = $clog2(VECTOR_REGISTERS * VECTOR_LANES) + 1;
  localparam int REGW             = $clog2(VECTOR_REGISTERS);

  typedef struct packed {
    logic [7:0]      op;
    logic [1:0]      fu;
    logic [REGW-1:0] src1;
    logic [REGW-1:0] src2;
    logic [REGW-1:0] dst;
    logic            reconfigure;
    logic [VLW-1:0]  vl;
    logic [VLW-1:0]  maxvl;
  } to_vector;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    CONFIG = 2'd2
  } vissue_state_e;

  // One-hot select of the functional-unit group addressed by fu.
  function automatic logic [3:0] fu_onehot(input logic [1:0] fu);
    return 4'b0001 << fu;
  endfunction

endpackage

// File: rtl/vector_issue_ctrl_if.sv
// Handshake/bus bundle of vector_issue_ctrl.
//   source side : valid_i, instr_i -> pop_o
//   FU side     : issue_valid_o/issue_instr_o -> issue_ready_i
//   writeback   : wb_valid_i, wb_dst_i
//   status      : vl_o, maxvl_o, idle_o, hazard_stalls_o, drain_stalls_o
// master = environment (source, FUs, writeback); slave = the controller.
interface vector_issue_ctrl_if;
  import vector_issue_ctrl_pkg::*;

  logic            valid_i;
  to_vector        instr_i;
  logic            pop_o;
  logic [3:0]      issue_valid_o;
  logic [3:0]      issue_ready_i;
  to_vector        issue_instr_o;
  logic            wb_valid_i;
  logic [REGW-1:0] wb_dst_i;
  logic [VLW-1:0]  vl_o;
  logic [VLW-1:0]  maxvl_o;
  logic            idle_o;
  logic [31:0]     hazard_stalls_o;
  logic [31:0]     drain_stalls_o;

  modport master (
    output valid_i, instr_i, issue_ready_i, wb_valid_i, wb_dst_i,
    input  pop_o, issue_valid_o, issue_instr_o, vl_o, maxvl_o, idle_o,
           hazard_stalls_o, drain_stalls_o
  );

  modport slave (
    input  valid_i, instr_i, issue_ready_i, wb_valid_i, wb_dst_i,
    output pop_o, issue_valid_o, issue_instr_o, vl_o, maxvl_o, idle_o,
           hazard_stalls_o, drain_stalls_o
  );

endinterface

// File: rtl/vector_issue_ctrl_scoreboard.sv
// Register-busy scoreboard (module vector_scoreboard).
//   clk, rst             : clock, async active-high reset
//   set_i/set_idx_i      : mark a register busy
//   clr_i/clr_idx_i      : release a register (applied before the set)
//   rd_idx_i[3]/busy_o   : combinational lookups of the registered state
//   empty_o              : no register busy
module vector_scoreboard #(
  parameter int VECTOR_REGISTERS = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                set_i,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0] set_idx_i,
  input  logic                                clr_i,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0] clr_idx_i,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0] rd_idx_i [3],
  output logic [2:0]                          busy_o,
  output logic                                empty_o
);

  logic [VECTOR_REGISTERS-1:0] busy_q;
  logic [VECTOR_REGISTERS-1:0] busy_d;
  logic [VECTOR_REGISTERS-1:0] one_s;

  assign one_s = {{(VECTOR_REGISTERS-1){1'b0}}, 1'b1};

  // Clear first, then set, so a same-index set in the same cycle wins.
  always_comb begin
    busy_d = (busy_q & ~(clr_i ? (one_s << clr_idx_i) : '0))
           | (set_i ? (one_s << set_idx_i) : '0);
  end

  // Lookups see the registered state only: no writeback bypass.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      busy_o[i] = busy_q[rd_idx_i[i]];
    end
    empty_o = ~|busy_q;
  end

  // Busy-bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/vector_issue_ctrl.sv
// Vector issue controller: takes instructions from the source, blocks RAW/WAW
// hazards through the scoreboard, holds one instruction in a registered issue
// stage for its FU group, and serialises vl/maxvl reconfiguration behind a
// full drain (RUN -> DRAIN -> CONFIG -> RUN).
//   clk, rst : clock, async active-high reset
//   bus      : vector_issue_ctrl_if.slave (source, FU, writeback, status)
// Optional feature macro VECTOR_ISSUE_PERF_EN: saturating hazard/drain stall
// counters; when undefined both counter outputs are tied to zero.
module vector_issue_ctrl
  import vector_issue_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  vector_issue_ctrl_if.slave   bus
);

  vissue_state_e   state_q, state_d;
  logic            full_q, full_d;
  to_vector        held_q, held_d;
  logic [VLW-1:0]  vl_q, vl_d;
  logic [VLW-1:0]  maxvl_q, maxvl_d;
  logic [REGW-1:0] rd_idx_s [3];
  logic [2:0]      busy_s;
  logic            sb_empty_s;
  logic            fire_s;
  logic            hazard_s;
  logic            load_s;
  logic            pop_s;

  assign rd_idx_s[0] = bus.instr_i.src1;
  assign rd_idx_s[1] = bus.instr_i.src2;
  assign rd_idx_s[2] = bus.instr_i.dst;

  vector_scoreboard #(.VECTOR_REGISTERS(VECTOR_REGISTERS)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_i     (load_s),
    .set_idx_i (bus.instr_i.dst),
    .clr_i     (bus.wb_valid_i),
    .clr_idx_i (bus.wb_dst_i),
    .rd_idx_i  (rd_idx_s),
    .busy_o    (busy_s),
    .empty_o   (sb_empty_s)
  );

  // FSM next state, issue-stage load/fire and configuration update.
  always_comb begin
    fire_s   = full_q & bus.issue_ready_i[held_q.fu];
    hazard_s = |busy_s;
    state_d  = state_q;
    full_d   = full_q & ~fire_s;
    held_d   = held_q;
    vl_d     = vl_q;
    maxvl_d  = maxvl_q;
    load_s   = 1'b0;
    pop_s    = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.valid_i & bus.instr_i.reconfigure) begin
          state_d = DRAIN;
        end else if (bus.valid_i & ~hazard_s & (~full_q | fire_s)) begin
          load_s       = 1'b1;
          pop_s        = 1'b1;
          full_d       = 1'b1;
          held_d       = bus.instr_i;
          held_d.vl    = vl_q;
          held_d.maxvl = maxvl_q;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // The reconfigure instruction must still be at the head to proceed.
        if (~full_q & sb_empty_s & bus.valid_i) begin
          state_d = CONFIG;
        end else begin
          state_d = DRAIN;
        end
      end
      CONFIG: begin
        if (bus.valid_i) begin
          pop_s   = 1'b1;
          vl_d    = bus.instr_i.vl;
          maxvl_d = bus.instr_i.maxvl;
          state_d = RUN;
        end else begin
          state_d = CONFIG;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, issue stage and configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      full_q  <= 1'b0;
      held_q  <= '0;
      vl_q    <= '0;
      maxvl_q <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      held_q  <= held_d;
      vl_q    <= vl_d;
      maxvl_q <= maxvl_d;
    end
  end

  assign bus.pop_o         = pop_s;
  assign bus.issue_valid_o = full_q ? fu_onehot(held_q.fu) : 4'b0000;
  assign bus.issue_instr_o = held_q;
  assign bus.vl_o          = vl_q;
  assign bus.maxvl_o       = maxvl_q;
  assign bus.idle_o        = (state_q == RUN) & ~full_q & sb_empty_s;

`ifdef VECTOR_ISSUE_PERF_EN
  logic [31:0] hz_q, hz_d;
  logic [31:0] dr_q, dr_d;

  // Saturating stall counters.
  always_comb begin
    if ((state_q == RUN) & bus.valid_i & ~bus.instr_i.reconfigure & hazard_s
        & (hz_q != {32{1'b1}})) begin
      hz_d = hz_q + 32'd1;
    end else begin
      hz_d = hz_q;
    end
    if ((state_q == DRAIN) & (dr_q != {32{1'b1}})) begin
      dr_d = dr_q + 32'd1;
    end else begin
      dr_d = dr_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_q <= 32'd0;
      dr_q <= 32'd0;
    end else begin
      hz_q <= hz_d;
      dr_q <= dr_d;
    end
  end

  assign bus.hazard_stalls_o = hz_q;
  assign bus.drain_stalls_o  = dr_q;
`else
  assign bus.hazard_stalls_o = 32'd0;
  assign bus.drain_stalls_o  = 32'd0;
`endif

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Self-checking bench for vector_issue_ctrl: a cycle-level reference model
// (issue stage as a queue, busy bits as a plain vector) checked on every
// negative edge, plus directed scenarios with hand-computed expectations.
module tb_vector_issue_ctrl;
  import vector_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_issue_ctrl_if bus();
  vector_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic to_vector mk(input logic [7:0] op, input logic [1:0] fu,
                                  input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [4:0] d, input logic rc,
                                  input logic [8:0] vl, input logic [8:0] mvl);
    to_vector t;
    t.op = op; t.fu = fu; t.src1 = s1; t.src2 = s2; t.dst = d;
    t.reconfigure = rc; t.vl = vl; t.maxvl = mvl;
    return t;
  endfunction

  // ---------------- source queue driver ----------------
  to_vector src_q[$];
  logic     pop_seen = 1'b0;

  task automatic drive_src();
    bus.valid_i = (src_q.size() != 0);
    bus.instr_i = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic push(input to_vector t);
    src_q.push_back(t);
    drive_src();
  endtask

  always @(posedge clk) begin
    #1;
    if (pop_seen && src_q.size() != 0) void'(src_q.pop_front());
    drive_src();
  end

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_DRAIN = 1, M_CONFIG = 2;
  int          m_mode;
  to_vector    m_stage[$];
  logic [31:0] m_busy;
  logic [8:0]  m_vl, m_maxvl;
  int unsigned m_hz, m_dr;

  always @(negedge clk) begin
    logic st_empty, sb_empty, fire, blocked, e_pop, e_idle;
    logic [3:0] e_iv;
    to_vector t;
    if (rst) begin
      m_mode = M_RUN; m_stage.delete(); m_busy = 32'd0;
      m_vl = 9'd0; m_maxvl = 9'd0; m_hz = 0; m_dr = 0;
    end
    pop_seen = bus.pop_o;
    st_empty = (m_stage.size() == 0);
    sb_empty = (m_busy == 32'd0);
    e_iv     = st_empty ? 4'b0000 : (4'b0001 << m_stage[0].fu);
    fire     = !st_empty && bus.issue_ready_i[m_stage[0].fu];
    blocked  = m_busy[bus.instr_i.src1] | m_busy[bus.instr_i.src2] | m_busy[bus.instr_i.dst];
    e_pop    = bus.valid_i &&
               ((m_mode == M_RUN && !bus.instr_i.reconfigure && !blocked && (st_empty || fire)) ||
                (m_mode == M_CONFIG));
    e_idle   = (m_mode == M_RUN) && st_empty && sb_empty;

    chk("pop", bus.pop_o, e_pop);
    chk("issue_valid", bus.issue_valid_o, e_iv);
    if (!st_empty) chk("issue_instr", bus.issue_instr_o, m_stage[0]);
    chk("vl", bus.vl_o, m_vl);
    chk("maxvl", bus.maxvl_o, m_maxvl);
    chk("idle", bus.idle_o, e_idle);
`ifdef VECTOR_ISSUE_PERF_EN
    chk("hazard_stalls", bus.hazard_stalls_o, m_hz);
    chk("drain_stalls", bus.drain_stalls_o, m_dr);
`else
    chk("hazard_stalls", bus.hazard_stalls_o, 0);
    chk("drain_stalls", bus.drain_stalls_o, 0);
`endif

    if (!rst) begin
      if (m_mode == M_RUN && bus.valid_i && !bus.instr_i.reconfigure && blocked
          && m_hz != 32'hFFFF_FFFF) m_hz++;
      if (m_mode == M_DRAIN && m_dr != 32'hFFFF_FFFF) m_dr++;
      if (fire) void'(m_stage.pop_front());
      if (bus.wb_valid_i) m_busy[bus.wb_dst_i] = 1'b0;
      case (m_mode)
        M_RUN: begin
          if (bus.valid_i && bus.instr_i.reconfigure) m_mode = M_DRAIN;
          else if (e_pop) begin
            t = bus.instr_i; t.vl = m_vl; t.maxvl = m_maxvl;
            m_stage.push_back(t);
            m_busy[bus.instr_i.dst] = 1'b1;
          end
        end
        M_DRAIN: if (st_empty && sb_empty && bus.valid_i) m_mode = M_CONFIG;
        default: if (bus.valid_i) begin
          m_vl = bus.instr_i.vl; m_maxvl = bus.instr_i.maxvl; m_mode = M_RUN;
        end
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
    bus.wb_valid_i = 1'b0;
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  task automatic wb(input logic [4:0] d);
    cyc(); bus.wb_valid_i = 1'b1; bus.wb_dst_i = d;
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.instr_i = '0; bus.issue_ready_i = 4'hF;
    bus.wb_valid_i = 1'b0; bus.wb_dst_i = 5'd0;
    repeat (2) cyc();
    samp();
    chk("rst_pop", bus.pop_o, 1'b0);
    chk("rst_issue_valid", bus.issue_valid_o, 4'b0000);
    chk("rst_vl", bus.vl_o, 9'd0);
    chk("rst_idle", bus.idle_o, 1'b1);
    chk("rst_hz", bus.hazard_stalls_o, 32'd0);

    // Streaming: dst 1..4 on fu 0..3.
    cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(8'h10 + 8'(i), 2'(i), 5'd20, 5'd21, 5'(i + 1), 1'b0, 9'd0, 9'd0));
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc();
      samp();
      chk("stream_pop", bus.pop_o, c < 4);
      chk("stream_iv", bus.issue_valid_o, (c >= 1) ? (4'b0001 << (c - 1)) : 4'b0000);
    end
    chk("stream_sb", dut.u_sb.busy_q, 32'h0000_001E);
    for (int d = 1; d <= 4; d++) wb(5'(d));
    cyc();

    // RAW: B reads dst of A.
    cyc();
    push(mk(8'h20, 2'd0, 5'd20, 5'd21, 5'd5, 1'b0, 9'd0, 9'd0));
    push(mk(8'h21, 2'd1, 5'd5, 5'd21, 5'd6, 1'b0, 9'd0, 9'd0));
    samp(); chk("raw_popA", bus.pop_o, 1'b1);
    for (int c = 1; c < 4; c++) begin cyc(); samp(); chk("raw_hold", bus.pop_o, 1'b0); end
    wb(5'd5); samp(); chk("raw_wb_cycle", bus.pop_o, 1'b0);
    cyc(); samp(); chk("raw_popB", bus.pop_o, 1'b1);
`ifdef VECTOR_ISSUE_PERF_EN
    chk("raw_hz_count", bus.hazard_stalls_o, 32'd4);
`endif
    wb(5'd6); cyc();

    // Backpressure on fu 2.
    cyc(); bus.issue_ready_i = 4'b1011;
    push(mk(8'hA5, 2'd2, 5'd20, 5'd21, 5'd8, 1'b0, 9'd0, 9'd0));
    push(mk(8'h30, 2'd0, 5'd20, 5'd21, 5'd10, 1'b0, 9'd0, 9'd0));
    samp(); chk("bp_pop0", bus.pop_o, 1'b1);
    for (int c = 1; c < 4; c++) begin
      cyc(); samp();
      chk("bp_iv", bus.issue_valid_o, 4'b0100);
      chk("bp_dst", bus.issue_instr_o.dst, 5'd8);
      chk("bp_op", bus.issue_instr_o.op, 8'hA5);
      chk("bp_nopop", bus.pop_o, 1'b0);
    end
    cyc(); bus.issue_ready_i = 4'hF; samp();
    chk("bp_fire_pop", bus.pop_o, 1'b1);
    chk("bp_fire_iv", bus.issue_valid_o, 4'b0100);
    cyc(); samp(); chk("bp_next_iv", bus.issue_valid_o, 4'b0001);
    wb(5'd8); wb(5'd10); cyc();

    // Reconfiguration behind busy dst 3.
    cyc();
    push(mk(8'h40, 2'd1, 5'd20, 5'd21, 5'd3, 1'b0, 9'd0, 9'd0));
    push(mk(8'h41, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 9'd17, 9'd64));
    push(mk(8'h42, 2'd0, 5'd20, 5'd21, 5'd11, 1'b0, 9'd0, 9'd0));
    samp(); chk("rc_pop0", bus.pop_o, 1'b1);
    for (int c = 1; c < 4; c++) begin cyc(); samp(); chk("rc_drain", bus.pop_o, 1'b0); end
    wb(5'd3); samp(); chk("rc_drain_wb", bus.pop_o, 1'b0);
    cyc(); samp(); chk("rc_drain_last", bus.pop_o, 1'b0);
    cyc(); samp(); chk("rc_config_pop", bus.pop_o, 1'b1); chk("rc_vl_old", bus.vl_o, 9'd0);
    cyc(); samp();
    chk("rc_vl_new", bus.vl_o, 9'd17);
    chk("rc_maxvl_new", bus.maxvl_o, 9'd64);
    chk("rc_next_pop", bus.pop_o, 1'b1);
`ifdef VECTOR_ISSUE_PERF_EN
    chk("rc_drain_count", bus.drain_stalls_o, 32'd4);
`endif
    cyc(); samp();
    chk("rc_issued_vl", bus.issue_instr_o.vl, 9'd17);
    chk("rc_issued_maxvl", bus.issue_instr_o.maxvl, 9'd64);
    wb(5'd11); cyc();

    // Same-cycle writeback of 7 and load of dst 9.
    cyc(); push(mk(8'h50, 2'd0, 5'd20, 5'd21, 5'd7, 1'b0, 9'd0, 9'd0));
    samp(); chk("sc_pop7", bus.pop_o, 1'b1);
    cyc();
    wb(5'd7); push(mk(8'h51, 2'd1, 5'd20, 5'd21, 5'd9, 1'b0, 9'd0, 9'd0));
    samp(); chk("sc_pop9", bus.pop_o, 1'b1);
    cyc(); samp();
    chk("sc_bit7", dut.u_sb.busy_q[7], 1'b0);
    chk("sc_bit9", dut.u_sb.busy_q[9], 1'b1);
    wb(5'd9); cyc();

    // Reset in DRAIN with dst 12 busy.
    cyc();
    push(mk(8'h60, 2'd0, 5'd20, 5'd21, 5'd12, 1'b0, 9'd0, 9'd0));
    push(mk(8'h61, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 9'd5, 9'd8));
    samp(); chk("rd_pop0", bus.pop_o, 1'b1);
    cyc(); samp(); chk("rd_nopop", bus.pop_o, 1'b0);
    cyc(); samp(); chk("rd_not_idle", bus.idle_o, 1'b0);
    cyc(); rst = 1'b1; src_q.delete(); drive_src(); #1;
    chk("rd_pop", bus.pop_o, 1'b0);
    chk("rd_iv", bus.issue_valid_o, 4'b0000);
    chk("rd_vl", bus.vl_o, 9'd0);
    chk("rd_maxvl", bus.maxvl_o, 9'd0);
    chk("rd_idle", bus.idle_o, 1'b1);
    chk("rd_sb", dut.u_sb.busy_q, 32'd0);
    cyc(); rst = 1'b0;
    push(mk(8'h70, 2'd3, 5'd20, 5'd21, 5'd1, 1'b0, 9'd0, 9'd0));
    samp(); chk("rd_after_pop", bus.pop_o, 1'b1);
    cyc(); samp(); chk("rd_after_iv", bus.issue_valid_o, 4'b1000);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
